// File: rtl/ahb_lite_dev_bridge.sv
// ahb_lite_dev_bridge
//   AHB-Lite slave front end that turns bus transfers into a req/ack device
//   handshake. The device stalls the bus by delaying dev_ack. A watchdog turns
//   a device that never acks into a two-cycle ERROR response. Illegal
//   transfers (bad size, misaligned, out of range) get the same ERROR response
//   and never reach the device.
//
// Ports
//   HCLK, HRESET             clock, asynchronous active-high reset
//   HSEL/HADDR/HTRANS/HSIZE  AHB address phase (sampled when HREADY=1)
//   HWRITE/HWDATA/HREADY     AHB write flag, write data, bus ready
//   HREADYOUT/HRESP/HRDATA   AHB slave response
//   dev_req/dev_we/dev_addr  device request, direction, word address
//   dev_strb/dev_wdata       byte lanes and write data
//   dev_ack/dev_rdata        device completion pulse and read data
//   dbg_state                current FSM state encoding
//
// Device handshake: dev_req rises with dev_we/dev_addr/dev_strb valid and holds
// them stable until the cycle dev_ack=1 is sampled (request consumed, dev_rdata
// valid in that same cycle) or until the watchdog drops dev_req. dev_ack while
// dev_req=0 carries no meaning and is ignored.

module ahb_lite_dev_bridge #(
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_LIMIT = 256,
  parameter int TIMEOUT    = 255,
  parameter int TO_WIDTH   = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic                  dev_req,
  output logic                  dev_we,
  output logic [ADDR_WIDTH-1:0] dev_addr,
  output logic [3:0]            dev_strb,
  output logic [31:0]           dev_wdata,
  input  logic                  dev_ack,
  input  logic [31:0]           dev_rdata,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_DONE = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  localparam logic [29:0]         LIMIT   = 30'(WORD_LIMIT);
  localparam bit                  WDOG_EN = (TIMEOUT != 0);
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t              state;
  logic [TO_WIDTH-1:0] to_cnt;

  logic                accept;
  logic                illegal;
  logic                bad_form;
  logic [29:0]         word_addr;
  logic [3:0]          strb_calc;
  logic                unused;

  // HTRANS[0] only separates NONSEQ from SEQ, which this slave treats alike.
  assign unused    = HTRANS[0];
  assign dbg_state = state;
  // Write data is not registered: the master holds HWDATA through the stalled
  // data phase, so the device sees it directly.
  assign dev_wdata = HWDATA;

  always_comb begin
    word_addr = HADDR[31:2];
    accept    = HSEL & HREADY & HTRANS[1];
    bad_form  = 1'b0;
    strb_calc = 4'b1111;
    case (HSIZE)
      3'd0: strb_calc = 4'b0001 << HADDR[1:0];
      3'd1: begin
        bad_form  = HADDR[0];
        strb_calc = 4'b0011 << HADDR[1:0];
      end
      3'd2:    bad_form = (HADDR[1:0] != 2'b00);
      default: bad_form = 1'b1;  // wider than a word
    endcase
    illegal = bad_form | (word_addr >= LIMIT);
  end

  // All bus and device outputs are registered alongside the state so they
  // always match the state they describe.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= S_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= '0;
      dev_req   <= 1'b0;
      dev_we    <= 1'b0;
      dev_addr  <= '0;
      dev_strb  <= '0;
      to_cnt    <= '0;
    end else begin
      case (state)
        // States in which HREADYOUT=1, so a new address phase can be taken;
        // accepting from DONE/ERR2 gives back-to-back transfers.
        S_IDLE, S_DONE, S_ERR2: begin
          if (accept && !illegal) begin
            state     <= S_REQ;
            HREADYOUT <= 1'b0;
            HRESP     <= 1'b0;
            dev_req   <= 1'b1;
            dev_we    <= HWRITE;
            dev_addr  <= HADDR[ADDR_WIDTH+1:2];
            dev_strb  <= strb_calc;
            to_cnt    <= '0;
          end else if (accept) begin
            state     <= S_ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= 1'b1;
          end else begin
            state     <= S_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
          end
        end
        S_REQ: begin
          to_cnt <= to_cnt + TO_WIDTH'(1);
          // An ack arriving on the expiry cycle still completes the transfer.
          if (dev_ack) begin
            state     <= S_DONE;
            HRDATA    <= dev_rdata;
            dev_req   <= 1'b0;
            HREADYOUT <= 1'b1;
          end else if (WDOG_EN && to_cnt == TO_LAST) begin
            state   <= S_ERR1;
            dev_req <= 1'b0;
            HRESP   <= 1'b1;
          end
        end
        S_ERR1: begin
          state     <= S_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
          dev_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_dev_bridge.sv
// tb_ahb_lite_dev_bridge
//   Drives pipelined AHB-Lite transfers (directed cases, then random ones)
//   into ahb_lite_dev_bridge with a small device model answering dev_req.
//   Expected bus responses and device requests are computed from the transfer
//   rules at issue time and queued; a bus monitor and the device model pop and
//   compare independently. A final directed block applies reset mid-request.

module tb_ahb_lite_dev_bridge;

  localparam int ADDR_WIDTH = 8;
  localparam int WORD_LIMIT = 200;
  localparam int TIMEOUT    = 4;
  localparam int TO_WIDTH   = 3;
  localparam int EXP_W      = 42;  // {resp, resp_before_ready, waits[7:0], hrdata[31:0]}
  localparam int DEV_W      = 85;  // {we, addr[7:0], strb[3:0], wdata, rdata, delay[7:0]}

  logic                  HCLK;
  logic                  HRESET;
  logic                  HSEL;
  logic [31:0]           HADDR;
  logic [1:0]            HTRANS;
  logic [2:0]            HSIZE;
  logic                  HWRITE;
  logic [31:0]           HWDATA;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;
  logic [31:0]           HRDATA;
  logic                  dev_req;
  logic                  dev_we;
  logic [ADDR_WIDTH-1:0] dev_addr;
  logic [3:0]            dev_strb;
  logic [31:0]           dev_wdata;
  logic                  dev_ack;
  logic [31:0]           dev_rdata;
  logic [2:0]            dbg_state;

  // Single-slave bus: HREADY is this slave's own HREADYOUT.
  assign HREADY = HREADYOUT;

  ahb_lite_dev_bridge #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .WORD_LIMIT(WORD_LIMIT),
    .TIMEOUT   (TIMEOUT),
    .TO_WIDTH  (TO_WIDTH)
  ) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .HSEL     (HSEL),
    .HADDR    (HADDR),
    .HTRANS   (HTRANS),
    .HSIZE    (HSIZE),
    .HWRITE   (HWRITE),
    .HWDATA   (HWDATA),
    .HREADY   (HREADY),
    .HREADYOUT(HREADYOUT),
    .HRESP    (HRESP),
    .HRDATA   (HRDATA),
    .dev_req  (dev_req),
    .dev_we   (dev_we),
    .dev_addr (dev_addr),
    .dev_strb (dev_strb),
    .dev_wdata(dev_wdata),
    .dev_ack  (dev_ack),
    .dev_rdata(dev_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    int          gap;
  } txn_t;

  int               tests = 0;
  int               fails = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [DEV_W-1:0] dev_q[$];
  txn_t             txn_q[$];
  logic [31:0]      last_cap;
  bit               mon_en;
  bit               dev_en;
  bit               abort;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected device request and bus response of one
  // accepted transfer, straight from the transfer rules.
  task automatic issue(input txn_t t);
    int unsigned a;
    int unsigned limit;
    int          sz;
    bit          legal;
    logic [3:0]  strb;
    logic        resp;
    int          waits;
    logic [31:0] hr;
    a     = t.addr;
    limit = WORD_LIMIT;
    sz    = int'(t.size);
    legal = (sz <= 2) && ((a % (1 << sz)) == 0) && ((a / 4) < limit);
    if (sz == 0)      strb = 4'(1 << (a % 4));
    else if (sz == 1) strb = 4'(3 << (a % 4));
    else              strb = 4'hF;
    if (!legal) begin
      resp  = 1'b1;
      waits = 1;
      hr    = last_cap;
    end else begin
      dev_q.push_back({t.we, 8'((a / 4) % 256), strb, t.wdata, t.rdata, 8'(t.delay)});
      if (t.delay < TIMEOUT) begin
        resp     = 1'b0;
        waits    = t.delay + 1;
        hr       = t.rdata;
        last_cap = t.rdata;
      end else begin
        resp  = 1'b1;
        waits = TIMEOUT + 1;
        hr    = last_cap;
      end
    end
    exp_q.push_back({resp, resp, 8'(waits), hr});
  endtask

  function automatic txn_t make(input logic we, input logic [31:0] addr, input logic [2:0] size,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input int delay, input int gap);
    txn_t t;
    t.we = we; t.addr = addr; t.size = size; t.wdata = wdata;
    t.rdata = rdata; t.delay = delay; t.gap = gap;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.we = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0:       t.addr = $urandom();
      1, 2:    t.addr = $urandom_range(WORD_LIMIT * 4 - 12, WORD_LIMIT * 4 + 12);
      default: t.addr = $urandom_range(0, 1023);
    endcase
    t.size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    if (t.size <= 3'd2 && $urandom_range(0, 1) == 1)
      t.addr = t.addr & ~((32'd1 << t.size) - 32'd1);
    t.wdata = $urandom();
    t.rdata = $urandom();
    t.delay = ($urandom_range(0, 6) == 0) ? $urandom_range(TIMEOUT, TIMEOUT + 3) : $urandom_range(0, TIMEOUT - 1);
    t.gap   = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 3);
    return t;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    HADDR  = $urandom();
    HSIZE  = 3'($urandom_range(0, 2));
    HWRITE = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0:       begin HSEL = 1'b0; HTRANS = 2'b10; end  // not selected
      1:       begin HSEL = 1'b1; HTRANS = 2'b01; end  // BUSY
      default: begin HSEL = 1'($urandom_range(0, 1)); HTRANS = 2'b00; end
    endcase
  endtask

  task automatic drive_addr(input txn_t t);
    HSEL   = 1'b1;
    HTRANS = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
    HADDR  = t.addr;
    HSIZE  = t.size;
    HWRITE = t.we;
  endtask

  // Pipelined master: an address phase is taken on each edge with HREADY=1,
  // and its data phase (HWDATA) starts right after.
  task automatic run_txns();
    txn_t cur;
    bit   have_addr;
    logic rdy;
    int   gap;
    int   stall;
    have_addr = 0;
    gap       = 0;
    stall     = 0;
    cur       = make(0, 0, 0, 0, 0, 0, 0);
    while (txn_q.size() != 0 || have_addr) begin
      @(negedge HCLK);
      rdy = HREADYOUT;
      @(posedge HCLK);
      #1;
      if (!rdy) begin
        stall++;
        if (stall > 50) begin
          check("hreadyout_stuck_low", rdy, 1'b1);
          abort = 1;
          return;
        end
      end else begin
        stall = 0;
        if (have_addr) begin
          issue(cur);
          HWDATA    = cur.wdata;
          have_addr = 0;
        end else begin
          HWDATA = $urandom();
        end
        if (gap > 0) begin
          gap--;
          drive_idle();
        end else if (txn_q.size() != 0) begin
          cur       = txn_q.pop_front();
          gap       = cur.gap;
          have_addr = 1;
          drive_addr(cur);
        end else begin
          drive_idle();
        end
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge HCLK);
      n++;
    end
    check("responses_drained", exp_q.size(), 0);
  endtask

  // ---------------- bus monitor ----------------
  initial begin : monitor
    int               waits;
    logic             last_resp;
    logic [EXP_W-1:0] e;
    waits     = 0;
    last_resp = 1'b0;
    forever begin
      @(negedge HCLK);
      if (!mon_en) begin
        waits     = 0;
        last_resp = 1'b0;
      end else if (exp_q.size() != 0) begin
        if (!HREADYOUT) begin
          waits++;
          last_resp = HRESP;
        end else begin
          e = exp_q.pop_front();
          check("hresp", HRESP, e[41]);
          check("hresp_before_ready", last_resp, e[40]);
          check("wait_states", waits, e[39:32]);
          check("hrdata", HRDATA, e[31:0]);
          waits     = 0;
          last_resp = 1'b0;
        end
      end
    end
  end

  // ---------------- device model ----------------
  initial begin : device
    bit               busy;
    int               cnt;
    logic [DEV_W-1:0] d;
    dev_ack   = 1'b0;
    dev_rdata = '0;
    busy      = 0;
    cnt       = 0;
    d         = '0;
    forever begin
      @(negedge HCLK);
      dev_ack = 1'b0;
      if (!dev_en) begin
        busy = 0;
      end else if (dev_req) begin
        if (!busy && dev_q.size() == 0) begin
          check("dev_req_unexpected", dev_req, 1'b0);
        end else begin
          if (!busy) begin
            d    = dev_q.pop_front();
            busy = 1;
            cnt  = 0;
          end
          check("dev_we", dev_we, d[84]);
          check("dev_addr", dev_addr, d[83:76]);
          check("dev_strb", dev_strb, d[75:72]);
          if (d[84]) check("dev_wdata", dev_wdata, d[71:40]);
          if (cnt == int'(d[7:0])) begin
            dev_ack   = 1'b1;
            dev_rdata = d[39:8];
          end else begin
            dev_rdata = $urandom();
          end
          cnt++;
        end
      end else begin
        busy = 0;
        // Late or stray acks while nothing is requested must be ignored.
        dev_ack   = ($urandom_range(0, 3) == 0);
        dev_rdata = $urandom();
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #500000;
    fails++;
    tests++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin : main
    HRESET   = 1'b1;
    HSEL     = 1'b0;
    HADDR    = '0;
    HTRANS   = 2'b00;
    HSIZE    = 3'd0;
    HWRITE   = 1'b0;
    HWDATA   = '0;
    last_cap = '0;
    mon_en   = 1;
    dev_en   = 1;
    abort    = 0;

    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check("reset_hreadyout", HREADYOUT, 1'b1);
    check("reset_hresp", HRESP, 1'b0);
    check("reset_hrdata", HRDATA, 32'h0);
    check("reset_dev_req", dev_req, 1'b0);
    check("reset_dev_we", dev_we, 1'b0);
    check("reset_dev_addr", dev_addr, 8'h0);
    check("reset_dev_strb", dev_strb, 4'h0);
    check("reset_state", dbg_state, 3'd0);
    HRESET = 1'b0;

    // Directed transfers, then random ones.
    txn_q.push_back(make(1, 32'h10, 3'd2, 32'hDEADBEEF, 32'h0BADF00D, 3, 1));  // 4 wait states, ack on expiry cycle
    txn_q.push_back(make(0, 32'h0B, 3'd0, 32'h0, 32'h11223344, 0, 1));         // byte lane 3
    txn_q.push_back(make(0, 32'h402, 3'd2, 32'h0, 32'h0, 0, 0));               // misaligned word
    txn_q.push_back(make(1, WORD_LIMIT * 4, 3'd2, 32'h1, 32'h0, 0, 0));        // first word past the limit
    txn_q.push_back(make(1, WORD_LIMIT * 4 - 4, 3'd2, 32'hA5A5A5A5, 32'h77, 1, 0));  // last legal word
    txn_q.push_back(make(0, 32'h20, 3'd1, 32'h0, 32'h0, TIMEOUT + 6, 2));      // device never acks
    txn_q.push_back(make(0, 32'h36, 3'd1, 32'h0, 32'hCAFE1234, 0, 0));         // pipelined read ...
    txn_q.push_back(make(1, 32'h44, 3'd2, 32'h12345678, 32'h9ABCDEF0, 2, 1));  // ... then write
    txn_q.push_back(make(0, 32'h40, 3'd3, 32'h0, 32'h0, 0, 0));                // size > word
    for (int i = 0; i < 150; i++) txn_q.push_back(rand_txn());
    run_txns();
    if (!abort) drain();
    check("dev_requests_drained", dev_q.size(), 0);

    // Reset while a request is outstanding.
    if (!abort) begin
      mon_en = 0;
      dev_en = 0;
      @(posedge HCLK);
      #1;
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h20; HSIZE = 3'd2; HWRITE = 1'b1;
      @(posedge HCLK);
      #1;
      HTRANS = 2'b00;
      HSEL   = 1'b0;
      HWDATA = 32'hCAFEF00D;
      @(negedge HCLK);
      check("req_before_reset", dev_req, 1'b1);
      @(posedge HCLK);
      #2;
      HRESET = 1'b1;
      #1;
      check("midreq_reset_dev_req", dev_req, 1'b0);
      check("midreq_reset_hreadyout", HREADYOUT, 1'b1);
      check("midreq_reset_hresp", HRESP, 1'b0);
      check("midreq_reset_dev_addr", dev_addr, 8'h0);
      check("midreq_reset_dev_strb", dev_strb, 4'h0);
      check("midreq_reset_state", dbg_state, 3'd0);
      @(negedge HCLK);
      HRESET   = 1'b0;
      last_cap = '0;
      mon_en   = 1;
      dev_en   = 1;
      txn_q.push_back(make(0, 32'h41, 3'd2, 32'h0, 32'h0, 0, 0));          // error keeps HRDATA at 0
      txn_q.push_back(make(0, 32'h40, 3'd2, 32'h0, 32'h5A5A1234, 1, 0));   // normal read after reset
      run_txns();
      if (!abort) drain();
      check("dev_requests_drained_end", dev_q.size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
